// File: rtl/hazard_ctrl.sv
// +-----------------------------------------------------------------------------+
// | hazard_ctrl : 5-stage pipeline hazard, forwarding, freeze and halt control  |
// | Optional: HAZARD_PERF_EN adds the stall_cycles counter.   Rev 1.0           |
// +-----------------------------------------------------------------------------+
`default_nettype none

module hazard_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic       ex_valid,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic       branch_taken,
  input  logic       id_valid,
  input  logic       mem_valid,
  input  logic       wb_valid,
  input  logic [4:0] mem_rd,
  input  logic [4:0] wb_rd,
  input  logic       mem_regwrite,
  input  logic       wb_regwrite,
  input  logic       mem_memread,
  input  logic       mem_memwrite,
  input  logic       dmem_ack,
  input  logic       halt_req,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       idex_en,
  output logic       exmem_en,
  output logic       memwb_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       dmem_req,
  output logic       mem_err,
  output logic       halt_ack
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] wait_cnt;
  logic       mem_access;
  logic       timeout_hit;
  logic       frozen;
  logic       branch;
  logic       load_use;

  // MEM-stage loads are not forwardable from EX/MEM; their data arrives via MEM/WB.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (mem_valid && mem_regwrite && !mem_memread && mem_rd != 5'd0 && mem_rd == rs)
      return 2'b01;
    else if (wb_valid && wb_regwrite && wb_rd != 5'd0 && wb_rd == rs)
      return 2'b10;
    else
      return 2'b00;
  endfunction

  assign fwd_a       = fwd_sel(ex_rs1);
  assign fwd_b       = fwd_sel(ex_rs2);
  assign mem_access  = mem_valid && (mem_memread || mem_memwrite);
  assign dmem_req    = mem_access;
  assign timeout_hit = (wait_cnt == TIMEOUT_CNT);
  assign frozen      = mem_access && !dmem_ack && !timeout_hit;
  assign branch      = ex_valid && branch_taken;
  assign load_use    = ex_valid && ex_memread && ex_rd != 5'd0 &&
                       ((ex_rd == id_rs1 && id_uses_rs1) || (ex_rd == id_rs2 && id_uses_rs2));

  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    exmem_en   = 1'b1;
    memwb_en   = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (frozen) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else begin
      if (branch) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
      // Draining stops fetch and feeds bubbles into ID unless ID is being held.
      if (state == DRAIN) begin
        if (!branch) pc_en = 1'b0;
        if (branch || !load_use) ifid_flush = 1'b1;
      end else if (state == HALTED) begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (halt_req) state_nxt = DRAIN;
      DRAIN: begin
        if (!halt_req)
          state_nxt = RUN;
        else if (!id_valid && !ex_valid && !mem_valid && !wb_valid)
          state_nxt = HALTED;
      end
      HALTED:  if (!halt_req) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RUN;
      wait_cnt <= 8'd0;
      mem_err  <= 1'b0;
      halt_ack <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= frozen ? wait_cnt + 8'd1 : 8'd0;
      halt_ack <= (state_nxt == HALTED);
      if (timeout_hit) mem_err <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cycles <= 32'd0;
    else if (state == RUN && !pc_en)
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (TIMEOUT=16).
`default_nettype none

module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_valid, ex_memread, branch_taken;
  logic       id_valid, mem_valid, wb_valid, mem_regwrite, wb_regwrite;
  logic       mem_memread, mem_memwrite, dmem_ack, halt_req;
  logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;
  logic [1:0] fwd_a, fwd_b;
  logic       dmem_req, mem_err, halt_ack;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cycles;
  logic [31:0] sc_snap;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_valid(ex_valid), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .branch_taken(branch_taken), .id_valid(id_valid),
    .mem_valid(mem_valid), .wb_valid(wb_valid), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .mem_regwrite(mem_regwrite), .wb_regwrite(wb_regwrite),
    .mem_memread(mem_memread), .mem_memwrite(mem_memwrite), .dmem_ack(dmem_ack),
    .halt_req(halt_req), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .dmem_req(dmem_req),
    .mem_err(mem_err), .halt_ack(halt_ack)
`ifdef HAZARD_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change 2ns after the edge, checks run 1ns later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_uses_rs1, id_uses_rs2, ex_valid, ex_memread, branch_taken} = '0;
    {id_valid, mem_valid, wb_valid, mem_regwrite, wb_regwrite} = '0;
    {mem_memread, mem_memwrite, dmem_ack} = '0;
  endtask

  // {pc,ifid,idex,exmem,memwb,ifid_flush,idex_flush}
  function automatic logic [6:0] ctl();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};
  endfunction

  initial begin
    idle();
    rst_n    = 1'b0;
    halt_req = 1'b0;
    tick(); tick(); #1;
    chk("rst_halt_ack", 32'(halt_ack), 32'd0);
    chk("rst_mem_err", 32'(mem_err), 32'd0);
    chk("rst_ctl", 32'(ctl()), 32'b1111100);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
`ifdef HAZARD_PERF_EN
    chk("rst_stall", stall_cycles, 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Load-use: lw x5 in EX, add reads x5 in ID.
    ex_valid = 1; ex_memread = 1; ex_rd = 5; id_valid = 1; id_rs1 = 5; id_uses_rs1 = 1; #1;
    chk("lu_ctl", 32'(ctl()), 32'b0011101);
    tick();
    idle();
    mem_valid = 1; mem_memread = 1; mem_regwrite = 1; mem_rd = 5; dmem_ack = 1;
    id_valid = 1; id_rs1 = 5; id_uses_rs1 = 1; ex_rs1 = 5; #1;
    chk("lu_no_repeat", 32'(ctl()), 32'b1111100);
    chk("lu_no_fwd_load_mem", 32'(fwd_a), 32'd0);
`ifdef HAZARD_PERF_EN
    chk("lu_stall_count", stall_cycles, 32'd1);
`endif
    tick();
    idle();
    wb_valid = 1; wb_regwrite = 1; wb_rd = 5; ex_valid = 1; ex_rs1 = 5; #1;
    chk("lu_fwd_a_wb", 32'(fwd_a), 32'd2);

    // Forwarding priority and x0.
    idle();
    mem_valid = 1; mem_regwrite = 1; mem_rd = 3; wb_valid = 1; wb_regwrite = 1; wb_rd = 3;
    ex_rs2 = 3; #1;
    chk("fwd_b_mem_prio", 32'(fwd_b), 32'd1);
    mem_valid = 0; #1;
    chk("fwd_b_wb", 32'(fwd_b), 32'd2);
    mem_valid = 1; mem_rd = 0; wb_rd = 0; ex_rs2 = 0; #1;
    chk("fwd_b_x0", 32'(fwd_b), 32'd0);
    tick();

    // Memory wait: store frozen 4 cycles, acked on the 5th.
    idle();
    mem_valid = 1; mem_memwrite = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("wait_frozen", 32'({dmem_req, ctl()}), 32'b10000000);
      tick();
    end
    dmem_ack = 1; #1;
    chk("wait_release", 32'({dmem_req, ctl()}), 32'b11111100);
    tick();
    idle(); #1;
    chk("wait_no_err", 32'(mem_err), 32'd0);

    // Timeout: never acked.
    mem_valid = 1; mem_memwrite = 1;
    for (int i = 0; i < 16; i++) begin
      #1;
      chk("to_frozen", 32'(ctl()), 32'b0000000);
      tick();
    end
    #1;
    chk("to_release", 32'(ctl()), 32'b1111100);
    chk("to_err_not_yet", 32'(mem_err), 32'd0);
    tick();
    idle(); #1;
    chk("to_err_set", 32'(mem_err), 32'd1);
    tick(); tick(); #1;
    chk("to_err_sticky", 32'(mem_err), 32'd1);
    rst_n = 0;
    tick(); #1;
    chk("to_err_reset", 32'(mem_err), 32'd0);
    rst_n = 1;
    tick();

    // Halt with three instructions in flight.
    id_valid = 1; ex_valid = 1; mem_valid = 1; mem_regwrite = 1; halt_req = 1; #1;
    chk("halt_run", 32'({halt_ack, ctl()}), 32'b01111100);
    tick();
    id_valid = 0; wb_valid = 1; #1;
    chk("halt_drain", 32'({halt_ack, ctl()}), 32'b00111110);
    tick();
    ex_valid = 0; tick();
    mem_valid = 0; tick();
    wb_valid = 0; #1;
    chk("halt_last_clear", 32'(halt_ack), 32'd0);
    tick(); #1;
    chk("halt_ack_rise", 32'({halt_ack, ctl()}), 32'b10111110);
    tick();
    halt_req = 0; #1;
    chk("halt_ack_hold", 32'(halt_ack), 32'd1);
    tick(); #1;
    chk("halt_exit", 32'({halt_ack, ctl()}), 32'b01111100);

    // Halt request withdrawn during drain, then reset during drain.
    id_valid = 1; halt_req = 1;
    tick(); #1;
    chk("drain_pc_off", 32'(pc_en), 32'd0);
    halt_req = 0;
    tick(); #1;
    chk("drain_abort", 32'(ctl()), 32'b1111100);
    halt_req = 1;
    tick();
    rst_n = 0;
    tick(); #1;
    chk("drain_reset", 32'({halt_ack, ctl()}), 32'b01111100);
    halt_req = 0; rst_n = 1;
    tick();

    // Branch and load-use together: branch wins.
    idle();
    ex_valid = 1; branch_taken = 1; ex_memread = 1; ex_rd = 7;
    id_valid = 1; id_rs2 = 7; id_uses_rs2 = 1; #1;
    chk("br_lu", 32'(ctl()), 32'b1111111);
`ifdef HAZARD_PERF_EN
    sc_snap = stall_cycles;
    tick(); #1;
    chk("br_lu_stall", stall_cycles, sc_snap);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
